// File: rtl/sound_mixer_i2s.sv
// Final audio stage: mixes four channel samples per side with enables and
// master volume, then serializes the stereo pair as a 64-BCLK I2S frame.
module sound_mixer_i2s #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [23:0] ch1_wave,
  input  logic [23:0] ch2_wave,
  input  logic [23:0] ch3_wave,
  input  logic [23:0] ch4_wave,
  input  logic [15:0] soundcnt_l,
  input  logic        sound_en,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_strobe
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  // Mix stage signals
  logic [23:0] ch [4];
  logic [25:0] sum_l, sum_r;
  logic [28:0] prod_l, prod_r;
  logic [23:0] word_l_d, word_r_d, word_l_q, word_r_q;

  // Serializer state
  logic [DivW-1:0] div_cnt_d, div_cnt_q;
  logic            bclk_d, bclk_q;
  logic [5:0]      bit_cnt_d, bit_cnt_q;
  logic            lrclk_d, lrclk_q;
  logic            sdata_d, sdata_q;
  logic            strobe_d, strobe_q;
  logic [23:0]     hold_l_d, hold_l_q, hold_r_d, hold_r_q;
  logic            div_wrap, bclk_fall;
  logic [4:0]      slot;
  logic [23:0]     cur_hold;

  assign ch[0] = ch1_wave;
  assign ch[1] = ch2_wave;
  assign ch[2] = ch3_wave;
  assign ch[3] = ch4_wave;

  // Per-side sum of enabled channels, scaled by (vol + 1) / 8, gated by master enable
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < 4; i++) begin
      if (soundcnt_l[12 + i]) sum_l = sum_l + 26'(ch[i]);
      if (soundcnt_l[8 + i])  sum_r = sum_r + 26'(ch[i]);
    end
    prod_l = 29'(sum_l) * 29'({1'b0, soundcnt_l[6:4]} + 4'd1);
    prod_r = 29'(sum_r) * 29'({1'b0, soundcnt_l[2:0]} + 4'd1);
    // prod >> 3 gives the 26-bit mix; its top 23 bits form a positive 24-bit word
    word_l_d = sound_en ? {1'b0, prod_l[28:6]} : 24'h0;
    word_r_d = sound_en ? {1'b0, prod_r[28:6]} : 24'h0;
  end

  // Mix result register: one cycle of input-to-word latency
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      word_l_q <= '0;
      word_r_q <= '0;
    end else begin
      word_l_q <= word_l_d;
      word_r_q <= word_r_d;
    end
  end

  // BCLK divider, bit counter, frame latch and serial data selection
  always_comb begin
    div_wrap  = (div_cnt_q == DivMax);
    bclk_fall = div_wrap && bclk_q;
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DivW'(1);
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    strobe_d  = 1'b0;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    slot      = bit_cnt_q[4:0];
    cur_hold  = hold_l_q;
    if (bclk_fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (bit_cnt_q == 6'd63) begin
        hold_l_d = word_l_q;
        hold_r_d = word_r_q;
        strobe_d = 1'b1;
      end
      slot     = bit_cnt_d[4:0];
      cur_hold = bit_cnt_d[5] ? hold_r_q : hold_l_q;
      // Slot 0 is the I2S one-bit delay; at the wrap it is always 0, so the
      // old hold value seen there is never transmitted.
      sdata_d  = 1'b0;
      if (slot >= 5'd1 && slot <= 5'd24) sdata_d = cur_hold[5'd24 - slot];
    end
  end

  // Serializer state register
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      lrclk_q   <= 1'b1;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      strobe_q  <= strobe_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign frame_strobe = strobe_q;

endmodule
